// File: rtl/demux_stream_1xn.sv
// 1-to-N valid/ready stream demux with one registered slot per output channel.
// Optional per-channel output transfer counters: define DEMUX_STREAM_CNT_EN.

module demux_stream_slot #(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             i_fill,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
`ifdef DEMUX_STREAM_CNT_EN
  ,
  output logic [15:0]      o_cnt
`endif
);
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             w_drain;

  assign w_drain = r_valid && i_ready;

  // A fill wins over a drain in the same cycle so the slot stays FULL with new data.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

`ifdef DEMUX_STREAM_CNT_EN
  logic [15:0] r_cnt;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in)                         r_cnt <= '0;
    else if (w_drain && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
  end

  assign o_cnt = r_cnt;
`endif
endmodule

module demux_stream_1xn #(
  parameter  int WIDTH = 16,
  parameter  int N_OUT = 4,
  localparam int SEL_W = $clog2(N_OUT)
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic [WIDTH-1:0]       data_in,
  input  logic [SEL_W-1:0]       sel_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  output logic [N_OUT*WIDTH-1:0] data_out,
  output logic [N_OUT-1:0]       valid_out,
  input  logic [N_OUT-1:0]       ready_in,
  output logic                   err_out
`ifdef DEMUX_STREAM_CNT_EN
  ,
  output logic [N_OUT*16-1:0]    cnt_out
`endif
);
  logic [N_OUT-1:0][WIDTH-1:0] w_data;
  logic [N_OUT-1:0]            w_valid;
  logic [N_OUT-1:0]            w_fill;
  logic                        w_ready;
  logic                        w_xfer;
  logic                        r_err;

  // An out-of-range select matches no lane and leaves ready at 1: the word is sunk.
  always_comb begin
    w_ready = 1'b1;
    for (int i = 0; i < N_OUT; i++)
      if (sel_in == SEL_W'(i)) w_ready = !w_valid[i] || ready_in[i];
  end

  assign w_xfer = valid_in && w_ready;

`ifdef DEMUX_STREAM_CNT_EN
  logic [N_OUT-1:0][15:0] w_cnt;
  assign cnt_out = w_cnt;
`endif

  for (genvar g = 0; g < N_OUT; g++) begin : g_lane
    assign w_fill[g] = w_xfer && (sel_in == SEL_W'(g));

    demux_stream_slot #(.WIDTH(WIDTH)) u_slot (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .i_fill   (w_fill[g]),
      .i_data   (data_in),
      .i_ready  (ready_in[g]),
      .o_valid  (w_valid[g]),
      .o_data   (w_data[g])
`ifdef DEMUX_STREAM_CNT_EN
      ,
      .o_cnt    (w_cnt[g])
`endif
    );
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) r_err <= 1'b0;
    else           r_err <= w_xfer && !(|w_fill);
  end

  assign ready_out = w_ready;
  assign valid_out = w_valid;
  assign data_out  = w_data;
  assign err_out   = r_err;
endmodule

// File: doc/demux_stream_1xn.md
Name: demux_stream_1xn

Overview:
- Parametrised 1-to-N stream demultiplexer for the hack_n2t datapath.
- Successor to the fixed 1x4 combinational demux: configurable data width and output channel count.
- Valid/ready handshake on every port, plus a one-entry registered slot per output channel.
- Out-of-range select detection.
- Sits between a single producer (CPU write path or bus master) and N consumers (memory banks, peripherals).

Parameters:
- WIDTH, 16, data word width in bits.
- N_OUT, 4, number of output channels; legal range 2..16, need not be a power of two.
- SEL_W, $clog2(N_OUT), select width; derived, not overridden.

Ports:
- clk_in  input  1  single clock; all state updates on rising edge.
- rst_n_in  input  1  reset; synchronous, active-low.
- data_in  input  WIDTH  input word.
- sel_in  input  SEL_W  destination channel for data_in.
- valid_in  input  1  producer has a word.
- ready_out  output  1  block accepts the word this cycle.
- data_out  output  N_OUT*WIDTH  flattened channel data; channel i at bits [i*WIDTH +: WIDTH].
- valid_out  output  N_OUT  channel i slot holds a word.
- ready_in  input  N_OUT  consumer i takes the word this cycle.
- err_out  output  1  one-cycle pulse: an out-of-range select was accepted and dropped.

Behaviour:
- Reset (rst_n_in=0 at a clock edge):
  - valid_out=0 and data_out=0 on all channels; err_out=0.
  - Any buffered words are discarded, including reset asserted mid-transfer.
  - ready_out is don't-care during reset; no transfer is recorded while rst_n_in=0.
- Per-channel slot: two states, EMPTY (valid_out[i]=0) and FULL (valid_out[i]=1).
- Input transfer: valid_in && ready_out on a clock edge.
- Output transfer on channel i: valid_out[i] && ready_in[i] on a clock edge.
- ready_out is combinational:
  - sel_in < N_OUT: ready_out = !valid_out[sel_in] || ready_in[sel_in].
  - sel_in >= N_OUT: ready_out = 1 (word is sunk).
- Latency: a word accepted at edge k appears on channel sel_in with valid_out set after edge k. One cycle, no bubble.
- Slot transitions for channel i:
  - EMPTY + fill → FULL; data latched.
  - FULL + drain, no fill → EMPTY; data_out[i] keeps its last value.
  - FULL + drain + fill in the same cycle → stays FULL with the new data. Full throughput is 1 word/cycle per channel.
  - FULL, no drain → hold. data_out[i] and valid_out[i] stay stable until drained; valid never retracts.
- Only the selected slot changes on an input transfer. Other channels drain independently and concurrently.
- Out-of-range select (only possible when N_OUT is not a power of two):
  - Word is accepted and dropped; no slot changes.
  - err_out=1 for the next cycle only.
  - Back-to-back drops keep err_out high for each such cycle.
- valid_in=0: ready_out still reflects sel_in, but no transfer occurs.
- No combinational path from data_in to data_out.

Optional Feature:
- Macro: DEMUX_STREAM_CNT_EN.
- Defined:
  - Adds output cnt_out, width N_OUT*16: per-channel 16-bit transfer counters, flattened the same way as data_out.
  - Counter i increments on each output transfer of channel i.
  - Counters saturate at 16'hFFFF and clear to 0 on reset.
  - Dropped out-of-range words are not counted.
- Not defined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n_in=0 for 3 cycles with valid_in=1 → valid_out=4'b0000, data_out=0, err_out=0, no slot filled.
- Single route: N_OUT=4, send 16'hA5A5 with sel=2, all ready_in=1 → valid_out=4'b0100 exactly one cycle later, data_out[47:32]=16'hA5A5, then EMPTY.
- Backpressure: ready_in[1]=0, send 16'h0001 then 16'h0002 to sel=1 → first held stable, ready_out=0 on the second; raise ready_in[1] → 16'h0002 loaded the same edge 16'h0001 drains.
- Streaming: 8 consecutive words 0..7 to sel=3 with ready_in[3]=1 → ready_out stays 1, channel 3 outputs 0..7 on consecutive cycles, no gaps.
- Independence: channel 0 stalled FULL, words to sel=1 and sel=2 → both delivered, channel 0 data unchanged.
- Out-of-range: N_OUT=3, sel=3, data 16'hDEAD → ready_out=1, err_out pulses one cycle, valid_out unchanged; with DEMUX_STREAM_CNT_EN, counters unchanged.
